// File: rtl/queue_pkg.sv
// Shared width helpers for the parametrised queue and its pointer counters.
package queue_pkg;

  // Pointer width: at least one bit so a single-entry queue still has a legal index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_queue_if.sv
// Ready/valid handshake bundle for both sides of the queue.
// master = producer/consumer environment, slave = the queue itself.
interface param_queue_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );
endinterface

// File: rtl/queue_wrap_ctr.sv
// Pointer counter that wraps explicitly at MAX-1, so MAX need not be a power of two.
module queue_wrap_ctr
  import queue_pkg::*;
#(
  parameter int unsigned MAX = 2,
  parameter int unsigned PW  = clog2_min1(MAX)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] value
);

  logic [PW-1:0] value_q;

  // Clear wins over increment; wrap back to zero after the last entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else if (inc) begin
      value_q <= (value_q == PW'(MAX - 1)) ? '0 : value_q + PW'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/param_queue.sv
// Parametrised ready/valid FIFO with optional pipe (enq at full) and flow (empty bypass)
// modes, synchronous flush, occupancy count and almost-full flag.
module param_queue
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PIPE      = 0,
  parameter int unsigned FLOW      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  localparam int unsigned CW       = count_width(DEPTH),
  localparam int unsigned PW       = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  param_queue_if.slave  q,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             maybe_full_q;
  logic             maybe_full_d;

  logic ptr_match;
  logic empty;
  logic full;
  logic fire_enq;
  logic fire_deq;
  logic bypass;
  logic do_enq;
  logic do_deq;
  logic clear;

  assign clear = reset | flush;

  queue_wrap_ctr #(
    .MAX (DEPTH),
    .PW  (PW)
  ) u_rptr (
    .clk   (clk),
    .clear (clear),
    .inc   (do_deq),
    .value (rptr)
  );

  queue_wrap_ctr #(
    .MAX (DEPTH),
    .PW  (PW)
  ) u_wptr (
    .clk   (clk),
    .clear (clear),
    .inc   (do_enq),
    .value (wptr)
  );

  // Status flags, handshakes and the bypass decision.
  always_comb begin
    ptr_match = (rptr == wptr);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;

    q.enq_ready = ~flush & (~full | ((PIPE != 0) & q.deq_ready));
    q.deq_valid = ~flush & (~empty | ((FLOW != 0) & q.enq_valid));
    q.deq_bits  = ((FLOW != 0) && empty) ? q.enq_bits : mem[rptr];

    fire_enq = q.enq_valid & q.enq_ready;
    fire_deq = q.deq_valid & q.deq_ready;

    // A bypassed beat never touches storage or pointers.
    bypass = (FLOW != 0) & empty & fire_deq;
    do_enq = fire_enq & ~bypass;
    do_deq = fire_deq & ~bypass;

    maybe_full_d = maybe_full_q;
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // Storage is deliberately not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wptr] <= q.enq_bits;
    end
  end

  // Full/empty disambiguation bit; reset has priority but both clear it.
  always_ff @(posedge clk) begin
    if (clear) begin
      maybe_full_q <= 1'b0;
    end else begin
      maybe_full_q <= maybe_full_d;
    end
  end

  // Occupancy derived from pointer distance, with full as the wrap-around case.
  always_comb begin
    if (full) begin
      count = CW'(DEPTH);
    end else if (wptr >= rptr) begin
      count = CW'(wptr) - CW'(rptr);
    end else begin
      count = CW'(DEPTH) + CW'(wptr) - CW'(rptr);
    end
    almost_full = (32'(count) >= AF_THRESH);
  end

`ifndef SYNTHESIS
  // Handshakes must never accept into a full queue or read an empty one outside their modes.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(fire_enq && full && (PIPE == 0)))
        else $error("param_queue: enqueue fired while full");
      assert (!(fire_deq && empty && (FLOW == 0)))
        else $error("param_queue: dequeue fired while empty");
    end
  end
`endif

endmodule

// File: tb/tb_param_queue.sv
// Directed bench for param_queue: three configurations exercised side by side.
module tb_param_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_a = 1'b0;
  logic flush_f = 1'b0;
  logic flush_b = 1'b0;

  logic [1:0] count_a;
  logic [1:0] count_f;
  logic [2:0] count_b;
  logic       af_a;
  logic       af_f;
  logic       af_b;

  param_queue_if #(.WIDTH(8)) if_a ();
  param_queue_if #(.WIDTH(8)) if_f ();
  param_queue_if #(.WIDTH(8)) if_b ();

  // DEPTH=3, pipe mode, default almost-full threshold (2).
  param_queue #(.WIDTH(8), .DEPTH(3), .PIPE(1), .FLOW(0)) u_a (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_a),
    .q           (if_a.slave),
    .count       (count_a),
    .almost_full (af_a)
  );

  // DEPTH=3, flow mode.
  param_queue #(.WIDTH(8), .DEPTH(3), .PIPE(0), .FLOW(1)) u_f (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_f),
    .q           (if_f.slave),
    .count       (count_f),
    .almost_full (af_f)
  );

  // DEPTH=4, almost-full threshold 2.
  param_queue #(.WIDTH(8), .DEPTH(4), .AF_THRESH(2)) u_b (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_b),
    .q           (if_b.slave),
    .count       (count_b),
    .almost_full (af_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ev;
    logic [7:0] eb;
    logic       dr;
    logic       er;
    logic       dv;
    logic [7:0] db;
    int         cnt;
    logic       af;
  } vec_t;

  vec_t vecs[9];
  int   mq[$];
  int   nxt;
  int   got;
  int   cyc;
  logic ev;
  logic dr;
  logic er_e;
  logic dv_e;

  initial begin
    // Fill to full, pipe-mode enq+deq at full, then drain (expected outputs before each edge).
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2, 1'b1};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3, 1'b1};
    vecs[4] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 3, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};

    if_a.enq_valid = 1'b0; if_a.enq_bits = 8'h00; if_a.deq_ready = 1'b0;
    if_f.enq_valid = 1'b0; if_f.enq_bits = 8'h00; if_f.deq_ready = 1'b0;
    if_b.enq_valid = 1'b0; if_b.enq_bits = 8'h00; if_b.deq_ready = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Post-reset state of every configuration.
    check("rst_a_cnt", 32'(count_a), 0);
    check("rst_a_er", 32'(if_a.enq_ready), 1);
    check("rst_a_dv", 32'(if_a.deq_valid), 0);
    check("rst_a_af", 32'(af_a), 0);
    check("rst_f_dv", 32'(if_f.deq_valid), 0);
    check("rst_b_cnt", 32'(count_b), 0);
    check("rst_b_af", 32'(af_b), 0);

    // Table-driven fill/pipe/drain on u_a.
    for (int i = 0; i < 9; i++) begin
      if_a.enq_valid = vecs[i].ev;
      if_a.enq_bits  = vecs[i].eb;
      if_a.deq_ready = vecs[i].dr;
      #1;
      check($sformatf("vec%0d_er", i), 32'(if_a.enq_ready), 32'(vecs[i].er));
      check($sformatf("vec%0d_dv", i), 32'(if_a.deq_valid), 32'(vecs[i].dv));
      check($sformatf("vec%0d_cnt", i), 32'(count_a), vecs[i].cnt);
      check($sformatf("vec%0d_af", i), 32'(af_a), 32'(vecs[i].af));
      if (vecs[i].dv) check($sformatf("vec%0d_bits", i), 32'(if_a.deq_bits), 32'(vecs[i].db));
      tick();
    end
    if_a.enq_valid = 1'b0;
    if_a.deq_ready = 1'b0;

    // Wrap-around: 10 values interleaved through u_a against a reference queue.
    nxt = 0;
    got = 0;
    cyc = 0;
    while ((nxt < 10 || mq.size() > 0) && cyc < 60) begin
      ev = (nxt < 10) && (cyc % 3 != 2);
      dr = (cyc % 2 == 1);
      if_a.enq_valid = ev;
      if_a.enq_bits  = 8'(nxt);
      if_a.deq_ready = dr;
      #1;
      er_e = (mq.size() < 3) || dr;
      dv_e = (mq.size() > 0);
      check("wrap_cnt", 32'(count_a), mq.size());
      check("wrap_er", 32'(if_a.enq_ready), 32'(er_e));
      check("wrap_dv", 32'(if_a.deq_valid), 32'(dv_e));
      if (dv_e) check("wrap_bits", 32'(if_a.deq_bits), mq[0]);
      if (dv_e && dr) begin
        void'(mq.pop_front());
        got++;
      end
      if (ev && er_e) begin
        mq.push_back(nxt);
        nxt++;
      end
      tick();
      cyc++;
    end
    check("wrap_total", got, 10);
    if_a.enq_valid = 1'b0;
    if_a.deq_ready = 1'b0;

    // Flow bypass on empty u_f: same-cycle pass-through, nothing stored.
    if_f.enq_valid = 1'b1; if_f.enq_bits = 8'hA5; if_f.deq_ready = 1'b1;
    #1;
    check("flow_dv", 32'(if_f.deq_valid), 1);
    check("flow_bits", 32'(if_f.deq_bits), 32'h A5);
    check("flow_er", 32'(if_f.enq_ready), 1);
    tick();
    if_f.enq_valid = 1'b0; if_f.deq_ready = 1'b0;
    #1;
    check("flow_cnt_after", 32'(count_f), 0);
    check("flow_dv_idle", 32'(if_f.deq_valid), 0);

    // Bypass data is visible but also stored when the consumer stalls.
    if_f.enq_valid = 1'b1; if_f.enq_bits = 8'h5A;
    #1;
    check("flow_stall_bits", 32'(if_f.deq_bits), 32'h5A);
    tick();
    if_f.enq_bits = 8'h66;
    #1;
    check("flow_stored_cnt", 32'(count_f), 1);
    check("flow_stored_bits", 32'(if_f.deq_bits), 32'h5A);
    tick();
    check("pre_flush_cnt", 32'(count_f), 2);

    // Flush with two entries while a producer and consumer are both active.
    flush_f = 1'b1; if_f.enq_bits = 8'h77; if_f.deq_ready = 1'b1;
    #1;
    check("flush_er", 32'(if_f.enq_ready), 0);
    check("flush_dv", 32'(if_f.deq_valid), 0);
    tick();
    flush_f = 1'b0; if_f.enq_valid = 1'b0; if_f.deq_ready = 1'b0;
    #1;
    check("post_flush_cnt", 32'(count_f), 0);
    check("post_flush_dv", 32'(if_f.deq_valid), 0);

    // Almost-full threshold and full-range count on u_b (DEPTH=4).
    if_b.enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_b.enq_bits = 8'(8'hB0 + i);
      #1;
      check($sformatf("af_cnt%0d", i), 32'(count_b), i);
      check($sformatf("af_flag%0d", i), 32'(af_b), 32'(i >= 2));
      tick();
    end
    check("b_full_cnt", 32'(count_b), 4);
    check("b_full_er", 32'(if_b.enq_ready), 0);
    check("b_head", 32'(if_b.deq_bits), 32'hB0);

    // Drain one, then reset in the middle of a refill.
    if_b.enq_valid = 1'b0; if_b.deq_ready = 1'b1;
    tick();
    if_b.deq_ready = 1'b0;
    check("b_cnt3", 32'(count_b), 3);
    check("b_head2", 32'(if_b.deq_bits), 32'hB1);
    reset = 1'b1; if_b.enq_valid = 1'b1; if_b.enq_bits = 8'hEE;
    tick();
    reset = 1'b0; if_b.enq_valid = 1'b0;
    #1;
    check("b_rst_cnt", 32'(count_b), 0);
    check("b_rst_af", 32'(af_b), 0);
    check("b_rst_dv", 32'(if_b.deq_valid), 0);
    check("b_rst_er", 32'(if_b.enq_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
